// File: rtl/encaps_pkg.sv
// Shared constants, FSM state encoding and the output strobe bundle for the
// NTRU-HRSS encapsulation sequencer.
package encaps_pkg;

  localparam int N_COEF      = 701;
  localparam int BLOCK_BYTES = 136;
  localparam int PACK_BYTES  = 280;
  localparam int N_BLOCKS    = (PACK_BYTES + BLOCK_BYTES - 1) / BLOCK_BYTES;
  localparam int LAST_BYTES  = PACK_BYTES - (N_BLOCKS - 1) * BLOCK_BYTES;

  // One width covers both the sampling-step count and the per-block byte count.
  localparam int CNT_W = $clog2(N_COEF + 1);

  localparam logic [CNT_W-1:0] N_COEF_L = CNT_W'(N_COEF);
  localparam logic [CNT_W-1:0] BLOCK_L  = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST_L   = CNT_W'(LAST_BYTES);
  localparam logic [1:0]       P3_LAST  = 2'(N_BLOCKS - 1);

  typedef enum logic [2:0] {
    ST_RST,
    ST_UNPACK,
    ST_SAMPLE,
    ST_PACK,
    ST_ABSORB,
    ST_PERMUTE,
    ST_SQUEEZE,
    ST_DONE
  } state_t;

  // Every single-bit control output, registered together.
  typedef struct packed {
    logic ovr_rst2;
    logic halt_n;
    logic sipo_u_clk;
    logic sipo_t1_clk;
    logic sipo_t2_clk;
    logic sipo_p_clk;
    logic sipo_p_stop;
    logic p3_rst;
    logic hash_rst1;
    logic hash_rst2;
    logic hash_sp;
    logic hash_ans;
    logic hash_keccak;
    logic hash_clk;
    logic enc_rst;
    logic lift_en;
  } ctl_t;

endpackage

// File: rtl/encaps_step_counter.sv
// Loadable down-counter. 'last' flags that the current decrement is the final
// one of the loaded run, so the FSM can leave a phase on the same edge.
module encaps_step_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; stalls at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last = (cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/encaps_control_unit.sv
// Encapsulation sequencer: unpack h, sample r/m, pack r||m into SHA3 rate
// blocks, absorb/permute each block, squeeze, then release the key register.
// Each registered output cycle reflects the action taken by the state that was
// current at the preceding clock edge.
module encaps_control_unit
  import encaps_pkg::*;
(
  input  logic       clk,
  input  logic       ovr_rst1,
  input  logic       up_rq0_done,
  input  logic       hash_fin,
  output logic       ovr_rst2,
  output logic       halt_n,
  output logic       sipo_u_clk,
  output logic       sipo_t1_clk,
  output logic       sipo_t2_clk,
  output logic       sipo_p_clk,
  output logic       sipo_p_stop,
  output logic       p3_rst,
  output logic [1:0] p3_count,
  output logic       hash_rst1,
  output logic       hash_rst2,
  output logic       hash_sp,
  output logic       hash_ans,
  output logic       hash_keccak,
  output logic       hash_clk,
  output logic       enc_rst,
  output logic       lift_en
);

  state_t           state;
  ctl_t             ctl;
  logic             ph;      // SAMPLE: 0 = phase A (t1), 1 = phase B (t2)
  logic             first;   // first cycle of PACK (block reset) or PERMUTE (start)
  logic             samp_last, byte_last;
  logic             samp_load, samp_dec, byte_load, byte_dec;
  logic [CNT_W-1:0] byte_init;

  // Counter control decoded from the current state; counters share the FSM reset.
  assign samp_load = (state == ST_UNPACK) && up_rq0_done;
  assign samp_dec  = (state == ST_SAMPLE) && ph;
  assign byte_load = (state == ST_PACK) && first;
  assign byte_dec  = (state == ST_PACK) && !first;
  assign byte_init = (p3_count == P3_LAST) ? LAST_L : BLOCK_L;

  encaps_step_counter #(.W(CNT_W)) u_samp_cnt (
    .clk      (clk),
    .rst      (ovr_rst1),
    .load     (samp_load),
    .load_val (N_COEF_L),
    .dec      (samp_dec),
    .last     (samp_last)
  );

  encaps_step_counter #(.W(CNT_W)) u_byte_cnt (
    .clk      (clk),
    .rst      (ovr_rst1),
    .load     (byte_load),
    .load_val (byte_init),
    .dec      (byte_dec),
    .last     (byte_last)
  );

  // Sequencer: next state, block index and the registered strobe bundle.
  always_ff @(posedge clk) begin
    if (ovr_rst1) begin
      state        <= ST_RST;
      ph           <= 1'b0;
      first        <= 1'b0;
      p3_count     <= '0;
      ctl          <= '0;
      ctl.halt_n   <= 1'b1;
      ctl.ovr_rst2 <= 1'b1;
    end else begin
      ctl        <= '0;
      ctl.halt_n <= 1'b1;
      case (state)
        ST_RST: begin
          ctl.ovr_rst2  <= 1'b1;
          ctl.hash_rst1 <= 1'b1;
          ctl.enc_rst   <= 1'b1;
          state         <= ST_UNPACK;
        end
        ST_UNPACK: begin
          if (up_rq0_done) begin
            state <= ST_SAMPLE;
            ph    <= 1'b0;
          end else begin
            ctl.sipo_u_clk <= 1'b1;
            ctl.enc_rst    <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          ctl.lift_en <= 1'b1;
          if (!ph) begin
            ctl.sipo_t1_clk <= 1'b1;
            ph              <= 1'b1;
          end else begin
            ctl.sipo_t2_clk <= 1'b1;
            ph              <= 1'b0;
            if (samp_last) begin
              state <= ST_PACK;
              first <= 1'b1;
            end
          end
        end
        ST_PACK: begin
          if (first) begin
            ctl.p3_rst <= 1'b1;
            first      <= 1'b0;
          end else begin
            ctl.sipo_p_clk <= 1'b1;
            if (byte_last) begin
              ctl.sipo_p_stop <= 1'b1;
              state           <= ST_ABSORB;
            end
          end
        end
        ST_ABSORB: begin
          ctl.hash_sp   <= 1'b1;
          ctl.hash_rst2 <= 1'b1;
          state         <= ST_PERMUTE;
          first         <= 1'b1;
        end
        ST_PERMUTE: begin
          if (first) begin
            ctl.hash_keccak <= 1'b1;
            first           <= 1'b0;
          end else if (hash_fin) begin
            if (p3_count == P3_LAST) begin
              state <= ST_SQUEEZE;
            end else begin
              p3_count <= p3_count + 2'd1;
              state    <= ST_PACK;
              first    <= 1'b1;
            end
          end else begin
            ctl.hash_clk <= 1'b1;
          end
        end
        ST_SQUEEZE: begin
          ctl.hash_ans <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          ctl.halt_n <= 1'b0;
        end
        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

  assign ovr_rst2    = ctl.ovr_rst2;
  assign halt_n      = ctl.halt_n;
  assign sipo_u_clk  = ctl.sipo_u_clk;
  assign sipo_t1_clk = ctl.sipo_t1_clk;
  assign sipo_t2_clk = ctl.sipo_t2_clk;
  assign sipo_p_clk  = ctl.sipo_p_clk;
  assign sipo_p_stop = ctl.sipo_p_stop;
  assign p3_rst      = ctl.p3_rst;
  assign hash_rst1   = ctl.hash_rst1;
  assign hash_rst2   = ctl.hash_rst2;
  assign hash_sp     = ctl.hash_sp;
  assign hash_ans    = ctl.hash_ans;
  assign hash_keccak = ctl.hash_keccak;
  assign hash_clk    = ctl.hash_clk;
  assign enc_rst     = ctl.enc_rst;
  assign lift_en     = ctl.lift_en;

endmodule

// File: tb/tb_encaps_control_unit.sv
// Randomized bench for the encapsulation sequencer. Expected pulse counts and
// block sizes come from the message geometry (coefficients, rate, packed size).
module tb_encaps_control_unit;

  localparam int NC = 701;
  localparam int BB = 136;
  localparam int PB = 280;
  localparam int NB = 3;

  logic       clk = 1'b0;
  logic       ovr_rst1, up_rq0_done, hash_fin;
  logic       ovr_rst2, halt_n, sipo_u_clk, sipo_t1_clk, sipo_t2_clk;
  logic       sipo_p_clk, sipo_p_stop, p3_rst;
  logic [1:0] p3_count;
  logic       hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_clk;
  logic       enc_rst, lift_en;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  encaps_control_unit dut (
    .clk         (clk),
    .ovr_rst1    (ovr_rst1),
    .up_rq0_done (up_rq0_done),
    .hash_fin    (hash_fin),
    .ovr_rst2    (ovr_rst2),
    .halt_n      (halt_n),
    .sipo_u_clk  (sipo_u_clk),
    .sipo_t1_clk (sipo_t1_clk),
    .sipo_t2_clk (sipo_t2_clk),
    .sipo_p_clk  (sipo_p_clk),
    .sipo_p_stop (sipo_p_stop),
    .p3_rst      (p3_rst),
    .p3_count    (p3_count),
    .hash_rst1   (hash_rst1),
    .hash_rst2   (hash_rst2),
    .hash_sp     (hash_sp),
    .hash_ans    (hash_ans),
    .hash_keccak (hash_keccak),
    .hash_clk    (hash_clk),
    .enc_rst     (enc_rst),
    .lift_en     (lift_en)
  );

  wire [13:0] strobes = {sipo_u_clk, sipo_t1_clk, sipo_t2_clk, sipo_p_clk,
                         sipo_p_stop, p3_rst, hash_rst1, hash_rst2, hash_sp,
                         hash_ans, hash_keccak, hash_clk, enc_rst, lift_en};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Bytes packed into block b of the r||m message.
  function automatic int blk_bytes(input int b);
    int rem;
    rem = PB - b * BB;
    return (rem < BB) ? rem : BB;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_halt_n"},   int'(halt_n),   1);
    chk({tag, "_ovr_rst2"}, int'(ovr_rst2), 1);
    chk({tag, "_strobes"},  int'(strobes),  0);
    chk({tag, "_p3_count"}, int'(p3_count), 0);
  endtask

  // One encapsulation from reset. fixed_lat > 0 pins the permutation latency,
  // otherwise it is random per block. abort fires a reset mid-permute of block 1.
  task automatic run_seq(input int u_target, input int fixed_lat, input bit abort);
    int u_cnt = 0, t1 = 0, t2 = 0, ovl = 0, alt = 0, lift = 0, last_t = 1;
    int pb[NB];
    int stop_cnt = 0, stop_bad = 0, p3rst = 0, sp = 0, rst2 = 0;
    int kec = 0, hclk = 0, exp_hclk = 0, ans = 0, pidx_bad = 0;
    int kec_idx[$];
    int lat, lat_left = -1;
    bit done_sent = 0, finished = 0, aborted = 0;
    for (int b = 0; b < NB; b++) pb[b] = 0;

    ovr_rst1 = 1'b1; up_rq0_done = 1'b0; hash_fin = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    ovr_rst1 = 1'b0;
    @(negedge clk);
    chk("exit_hash_rst1", int'(hash_rst1), 1);
    chk("exit_enc_rst",   int'(enc_rst),   1);
    chk("exit_ovr_rst2",  int'(ovr_rst2),  1);

    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      @(negedge clk);
      up_rq0_done = 1'b0;
      hash_fin    = 1'b0;
      // observe
      if (sipo_u_clk) u_cnt++;
      if (sipo_t1_clk && sipo_t2_clk) ovl++;
      if (sipo_t1_clk) begin
        t1++; if (last_t == 0) alt++; last_t = 0; if (!lift_en) lift++;
      end
      if (sipo_t2_clk) begin
        t2++; if (last_t == 1) alt++; last_t = 1; if (!lift_en) lift++;
      end
      if (sipo_p_clk) begin
        if (p3_count < NB) pb[p3_count]++;
        else pidx_bad++;
      end
      if (sipo_p_stop) begin
        stop_cnt++;
        if (!sipo_p_clk || p3_count >= NB) stop_bad++;
        else if (pb[p3_count] != blk_bytes(int'(p3_count))) stop_bad++;
      end
      if (p3_rst)    p3rst++;
      if (hash_sp)   sp++;
      if (hash_rst2) rst2++;
      if (hash_clk)  hclk++;
      if (hash_ans)  ans++;
      if (!halt_n)   finished = 1;
      // stimulus
      if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) hash_fin = 1'b1;
      end
      if (hash_keccak) begin
        kec++;
        kec_idx.push_back(int'(p3_count));
        lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(2, 30));
        exp_hclk += lat - 1;
        lat_left = lat - 1;
      end
      if (!done_sent && u_cnt == u_target) begin
        up_rq0_done = 1'b1;
        done_sent   = 1;
      end
      if ((sipo_t1_clk || sipo_t2_clk) && $urandom_range(0, 15) == 0) hash_fin = 1'b1;
      if (sipo_p_clk && $urandom_range(0, 7) == 0) up_rq0_done = 1'b1;
      if (abort && hash_clk && p3_count == 2'd1) begin
        ovr_rst1 = 1'b1;
        @(negedge clk);
        chk_reset("abort");
        aborted  = 1;
        finished = 1;
      end
    end

    if (abort) begin
      chk("abort_reached", int'(aborted), 1);
      return;
    end
    chk("done_reached", int'(finished), 1);
    chk("u_pulses", u_cnt, u_target);
    chk("t1_pulses", t1, NC);
    chk("t2_pulses", t2, NC);
    chk("t_overlap", ovl, 0);
    chk("t_alternate", alt, 0);
    chk("lift_en_low", lift, 0);
    for (int b = 0; b < NB; b++) chk($sformatf("pack_bytes_%0d", b), pb[b], blk_bytes(b));
    chk("p3_idx_range", pidx_bad, 0);
    chk("p_stop_cnt", stop_cnt, NB);
    chk("p_stop_place", stop_bad, 0);
    chk("p3_rst_cnt", p3rst, NB);
    chk("hash_sp_cnt", sp, NB);
    chk("hash_rst2_cnt", rst2, NB);
    chk("keccak_cnt", kec, NB);
    for (int b = 0; b < kec_idx.size(); b++) chk($sformatf("keccak_blk_%0d", b), kec_idx[b], b);
    chk("hash_clk_cnt", hclk, exp_hclk);
    chk("hash_ans_cnt", ans, 1);
    // DONE holds regardless of stray inputs
    for (int k = 0; k < 4; k++) begin
      up_rq0_done = 1'($urandom_range(0, 1));
      hash_fin    = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("done_halt_n", int'(halt_n), 0);
      chk("done_strobes", int'(strobes), 0);
    end
    up_rq0_done = 1'b0;
    hash_fin    = 1'b0;
  endtask

  initial begin
    ovr_rst1 = 1'b1; up_rq0_done = 1'b0; hash_fin = 1'b0;
    run_seq(10, 24, 1'b0);
    run_seq(int'($urandom_range(3, 12)), 0, 1'b1);
    run_seq(int'($urandom_range(1, 20)), 0, 1'b0);
    run_seq(int'($urandom_range(1, 20)), 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
